// File: rtl/scan_mux_led_if.sv
// Channel bus for scan_mux_led: packed channel data and controls in, LED data and
// channel status out. NCH and W must match the parameters of the attached mux.
interface scan_mux_led_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned W   = 1
);
    localparam int unsigned SELW = (NCH <= 2) ? 1 : $clog2(NCH);

    logic [NCH*W-1:0] din;
    logic [SELW-1:0]  sel;
    logic             mode;
    logic [NCH-1:0]   en_mask;
    logic [W-1:0]     dout;
    logic [SELW-1:0]  ch;
    logic             chg;

    // master drives the channel data and controls; slave is the mux itself
    modport master (
        output din, sel, mode, en_mask,
        input  dout, ch, chg
    );

    modport slave (
        input  din, sel, mode, en_mask,
        output dout, ch, chg
    );
endinterface

// File: rtl/scan_mux_led.sv
// Registered NCH-channel, W-bit LED multiplexer with manual select and auto-scan.
// Auto-scan dwells DIV cycles per channel and skips channels cleared in en_mask.
// Optional feature: define MUX_BLANK_EN to blank dout for BLANK_CYC cycles after
// every channel change (default build has no blanking state).
module scan_mux_led #(
    parameter int unsigned NCH       = 4,
    parameter int unsigned W         = 1,
    parameter int unsigned DIV       = 12000000,
    parameter int unsigned BLANK_CYC = 2
) (
    input logic           clk,
    input logic           rst,
    scan_mux_led_if.slave bus
);
    localparam int unsigned SELW = (NCH <= 2) ? 1 : $clog2(NCH);
    localparam int unsigned PW   = (DIV <= 2) ? 1 : $clog2(DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

`ifdef MUX_BLANK_EN
    localparam int unsigned BCW = (BLANK_CYC <= 2) ? 1 : $clog2(BLANK_CYC);
    localparam logic [BCW-1:0] BLANK_LAST = BCW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {StMan, StScan, StBlank} state_e;
`else
    typedef enum logic [0:0] {StMan, StScan} state_e;
`endif

    state_e          state_q;
    logic [PW-1:0]   presc_q;
    logic [SELW-1:0] ch_q;
    logic [W-1:0]    dout_q;
    logic            chg_q;

`ifdef MUX_BLANK_EN
    logic [BCW-1:0]  blank_q;
    logic            ret_scan_q;  // mode state to resume after blanking
`endif

    logic            sel_ok;
    logic            man_move;
    logic            mask_none;
    logic [SELW-1:0] nxt_ch;
    logic [SELW-1:0] hi_ch;
    logic [SELW-1:0] lo_ch;
    logic            hi_hit;
    logic            lo_hit;

    // Channel slice of the packed data bus; c is always a valid channel here
    function automatic logic [W-1:0] pick(input logic [NCH*W-1:0] d,
                                          input logic [SELW-1:0]  c);
        logic [W-1:0] r;
        r = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (c == SELW'(k)) begin
                r = d[k*W +: W];
            end
        end
        return r;
    endfunction

    // Manual select is only honoured for existing channels (non-power-of-2 NCH)
    if (NCH == (1 << SELW)) begin : g_sel_full
        assign sel_ok = 1'b1;
    end else begin : g_sel_part
        assign sel_ok = (bus.sel < SELW'(NCH));
    end

    assign man_move  = sel_ok && (bus.sel != ch_q);
    assign mask_none = (bus.en_mask == '0);

    // Circular search for the next enabled channel starting at ch+1: the first
    // enabled channel above ch wins, otherwise the first one at or below ch.
    // If only ch itself is enabled, or none are, the result is ch (hold).
    always_comb begin
        hi_ch  = ch_q;
        lo_ch  = ch_q;
        hi_hit = 1'b0;
        lo_hit = 1'b0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (!hi_hit && bus.en_mask[k] && (SELW'(k) > ch_q)) begin
                hi_hit = 1'b1;
                hi_ch  = SELW'(k);
            end
            if (!lo_hit && bus.en_mask[k] && (SELW'(k) <= ch_q)) begin
                lo_hit = 1'b1;
                lo_ch  = SELW'(k);
            end
        end
        nxt_ch = hi_hit ? hi_ch : lo_ch;
    end

    // Mode FSM with registered ch/dout/chg; ch and dout always move on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StMan;
            presc_q    <= '0;
            ch_q       <= '0;
            dout_q     <= '0;
            chg_q      <= 1'b0;
`ifdef MUX_BLANK_EN
            blank_q    <= '0;
            ret_scan_q <= 1'b0;
`endif
        end else begin
            chg_q <= 1'b0;
            unique case (state_q)
                StMan: begin
                    if (bus.mode) begin
                        // Entry into scan keeps ch; first advance is DIV cycles later
                        state_q <= StScan;
                        presc_q <= '0;
                        dout_q  <= mask_none ? '0 : pick(bus.din, ch_q);
                    end else if (man_move) begin
                        ch_q  <= bus.sel;
                        chg_q <= 1'b1;
`ifdef MUX_BLANK_EN
                        state_q    <= StBlank;
                        ret_scan_q <= 1'b0;
                        blank_q    <= '0;
                        dout_q     <= '0;
`else
                        dout_q <= pick(bus.din, bus.sel);
`endif
                    end else begin
                        dout_q <= pick(bus.din, ch_q);
                    end
                end

                StScan: begin
                    if (!bus.mode) begin
                        // Leaving scan beats a coincident terminal count
                        state_q <= StMan;
                        presc_q <= '0;
                        if (man_move) begin
                            ch_q  <= bus.sel;
                            chg_q <= 1'b1;
`ifdef MUX_BLANK_EN
                            state_q    <= StBlank;
                            ret_scan_q <= 1'b0;
                            blank_q    <= '0;
                            dout_q     <= '0;
`else
                            dout_q <= pick(bus.din, bus.sel);
`endif
                        end else begin
                            dout_q <= pick(bus.din, ch_q);
                        end
                    end else if (presc_q == PRESC_LAST) begin
                        presc_q <= '0;
                        if (nxt_ch != ch_q) begin
                            ch_q  <= nxt_ch;
                            chg_q <= 1'b1;
`ifdef MUX_BLANK_EN
                            state_q    <= StBlank;
                            ret_scan_q <= 1'b1;
                            blank_q    <= '0;
                            dout_q     <= '0;
`else
                            dout_q <= pick(bus.din, nxt_ch);
`endif
                        end else begin
                            dout_q <= mask_none ? '0 : pick(bus.din, ch_q);
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                        dout_q  <= mask_none ? '0 : pick(bus.din, ch_q);
                    end
                end

`ifdef MUX_BLANK_EN
                StBlank: begin
                    // Prescaler is frozen here; mode is re-evaluated after exit
                    dout_q <= '0;
                    if (!ret_scan_q && man_move) begin
                        ch_q    <= bus.sel;
                        chg_q   <= 1'b1;
                        blank_q <= '0;
                    end else if (blank_q == BLANK_LAST) begin
                        state_q <= ret_scan_q ? StScan : StMan;
                        dout_q  <= (ret_scan_q && mask_none) ? '0 : pick(bus.din, ch_q);
                    end else begin
                        blank_q <= blank_q + BCW'(1);
                    end
                end

                default: state_q <= StMan;
`endif
            endcase
        end
    end

    assign bus.dout = dout_q;
    assign bus.ch   = ch_q;
    assign bus.chg  = chg_q;

endmodule

// File: tb/tb_scan_mux_led.sv
// Bench for scan_mux_led: two instances (4ch x 1b, DIV=3 and 3ch x 2b, DIV=2)
// checked every cycle against a mode-level reference model, plus directed steps.
module tb_scan_mux_led;
    localparam int NCH_A = 4;
    localparam int W_A   = 1;
    localparam int DIV_A = 3;
    localparam int NCH_B = 3;
    localparam int W_B   = 2;
    localparam int DIV_B = 2;

    logic clk = 1'b0;
    logic rst;

    scan_mux_led_if #(.NCH(NCH_A), .W(W_A)) ia ();
    scan_mux_led_if #(.NCH(NCH_B), .W(W_B)) ib ();

    scan_mux_led #(.NCH(NCH_A), .W(W_A), .DIV(DIV_A), .BLANK_CYC(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    scan_mux_led #(.NCH(NCH_B), .W(W_B), .DIV(DIV_B), .BLANK_CYC(2)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    always #5 clk = ~clk;

    int    n_tests = 0;
    int    n_fail  = 0;
    string phase   = "init";

    // Reference model state per instance
    int m_ch[2];
    int m_dout[2];
    int m_chg[2];
    int m_scan[2];
    int m_presc[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, obs, exp);
        end
    endtask

    // One clock edge of the behavioural model, from the rules in plain arithmetic
    task automatic model_step(input int k, input int nch, input int w, input int div,
                              input int din, input int sel, input int mode,
                              input int mask, input int r);
        int nxt;
        int c;
        bit found;
        if (r != 0) begin
            m_ch[k]    = 0;
            m_dout[k]  = 0;
            m_chg[k]   = 0;
            m_scan[k]  = 0;
            m_presc[k] = 0;
        end else begin
            nxt = m_ch[k];
            if (mode == 0) begin
                m_scan[k] = 0;
                if (sel < nch) nxt = sel;
            end else if (m_scan[k] == 0) begin
                m_scan[k]  = 1;
                m_presc[k] = 0;
            end else if (m_presc[k] == div - 1) begin
                m_presc[k] = 0;
                found = 1'b0;
                for (int i = 1; i <= nch; i++) begin
                    c = (m_ch[k] + i) % nch;
                    if (!found && mask[c]) begin
                        found = 1'b1;
                        nxt   = c;
                    end
                end
            end else begin
                m_presc[k] = m_presc[k] + 1;
            end
            m_chg[k] = (nxt != m_ch[k]) ? 1 : 0;
            m_ch[k]  = nxt;
            if (m_scan[k] != 0 && mask == 0) m_dout[k] = 0;
            else m_dout[k] = (din >> (nxt * w)) & ((1 << w) - 1);
        end
    endtask

    // Advance one cycle, update the model from the sampled inputs, compare after the edge
    task automatic tick();
        @(posedge clk);
        model_step(0, NCH_A, W_A, DIV_A, int'(ia.din), int'(ia.sel), int'(ia.mode),
                   int'(ia.en_mask), int'(rst));
        model_step(1, NCH_B, W_B, DIV_B, int'(ib.din), int'(ib.sel), int'(ib.mode),
                   int'(ib.en_mask), int'(rst));
        #1;
        check("A.ch",   32'(ia.ch),   32'(m_ch[0]));
        check("A.dout", 32'(ia.dout), 32'(m_dout[0]));
        check("A.chg",  32'(ia.chg),  32'(m_chg[0]));
        check("B.ch",   32'(ib.ch),   32'(m_ch[1]));
        check("B.dout", 32'(ib.dout), 32'(m_dout[1]));
        check("B.chg",  32'(ib.chg),  32'(m_chg[1]));
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        ia.din     = '0;
        ia.sel     = '0;
        ia.mode    = 1'b0;
        ia.en_mask = '0;
        ib.din     = '0;
        ib.sel     = '0;
        ib.mode    = 1'b0;
        ib.en_mask = '0;

        phase = "reset";
        tick();
        tick();
        check("A.ch_rst", 32'(ia.ch), 32'd0);
        check("A.dout_rst", 32'(ia.dout), 32'd0);
        rst = 1'b0;

        // Manual sweep over all channels of a 1010 pattern
        phase = "man_sweep";
        ia.din = 4'b1010;
        for (int s = 0; s < 4; s++) begin
            ia.sel = 2'(s);
            tick();
        end
        check("A.dout_sel3", 32'(ia.dout), 32'd1);

        // Full-mask scan from reset
        phase = "scan_full";
        rst        = 1'b1;
        ia.mode    = 1'b1;
        ia.en_mask = 4'b1111;
        tick();
        rst = 1'b0;
        repeat (16) tick();

        // Sparse mask, then empty mask
        phase = "scan_sparse";
        rst        = 1'b1;
        ib.mode    = 1'b1;
        ib.en_mask = 3'b101;
        ib.din     = 6'b111001;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        phase = "scan_empty";
        ib.en_mask = 3'b000;
        repeat (6) tick();
        check("B.dout_empty", 32'(ib.dout), 32'd0);

        // Out-of-range select on the 3-channel instance
        phase = "sel_range";
        ib.mode = 1'b0;
        ib.sel  = 2'd1;
        tick();
        ib.sel = 2'd3;
        tick();
        check("B.ch_hold", 32'(ib.ch), 32'd1);
        check("B.chg_hold", 32'(ib.chg), 32'd0);

        // Reset in the middle of a dwell
        phase = "rst_mid";
        ib.mode    = 1'b1;
        ib.en_mask = 3'b111;
        tick();
        n = 0;
        while (m_presc[1] != 1 && n < 20) begin
            tick();
            n++;
        end
        if (m_presc[1] != 1) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s/wait_presc: observed %0d expected 1", phase, m_presc[1]);
        end
        rst = 1'b1;
        tick();
        check("B.ch_rst", 32'(ib.ch), 32'd0);
        check("B.chg_rst", 32'(ib.chg), 32'd0);
        rst = 1'b0;

        // Leave scan exactly on the terminal count, at a point where an advance
        // would not land on channel 2
        phase = "mode_tc";
        ia.mode    = 1'b1;
        ia.en_mask = 4'b1111;
        tick();
        n = 0;
        while (!(m_scan[0] == 1 && m_presc[0] == DIV_A - 1 && m_ch[0] != 1) && n < 40) begin
            tick();
            n++;
        end
        if (!(m_scan[0] == 1 && m_presc[0] == DIV_A - 1)) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s/wait_tc: observed %0d expected %0d", phase, m_presc[0], DIV_A - 1);
        end
        ia.mode = 1'b0;
        ia.sel  = 2'd2;
        tick();
        check("A.ch_tc", 32'(ia.ch), 32'd2);

        // Randomised traffic on both instances
        phase = "random";
        for (int i = 0; i < 600; i++) begin
            ia.din = 4'($urandom);
            ib.din = 6'($urandom);
            ia.sel = 2'($urandom_range(0, 3));
            ib.sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) ia.mode = ~ia.mode;
            if ($urandom_range(0, 7) == 0) ib.mode = ~ib.mode;
            if ($urandom_range(0, 15) == 0) ia.en_mask = 4'($urandom);
            if ($urandom_range(0, 15) == 0) ib.en_mask = 3'($urandom);
            if ($urandom_range(0, 31) == 0) ia.en_mask = '0;
            rst = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
